// File: rtl/count_issuer_if.sv
// count_issuer_if: request, count-unit and response signals of the count issuer.
interface count_issuer_if #(parameter int W = 8);
  logic         req_valid;
  logic         req_ready;
  logic [W-1:0] req_data;
  logic [1:0]   req_sel;
  logic         start;
  logic [W-1:0] a_in;
  logic [1:0]   sel;
  logic         done;
  logic [W-1:0] cntout;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [W-1:0] rsp_cnt;
  logic         rsp_err;
  modport master (
    input  req_valid, req_data, req_sel, done, cntout, rsp_ready,
    output req_ready, start, a_in, sel, rsp_valid, rsp_cnt, rsp_err
  );
  modport slave (
    output req_valid, req_data, req_sel, done, cntout, rsp_ready,
    input  req_ready, start, a_in, sel, rsp_valid, rsp_cnt, rsp_err
  );
endinterface

// File: rtl/count_issuer.sv
// count_issuer: queues count requests, issues them one at a time to the count unit, returns results.
// Define CNT_CHECK_EN to flag count-unit results that disagree with a locally computed reference.
module count_issuer #(
  parameter int W       = 8,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 12
) (
  input logic            clk,
  input logic            rst,
  count_issuer_if.master bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int TW = $clog2(TIMEOUT + 1);
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, ILLEGAL, RESP} state_t;
  state_t        state, nxt;
  logic [AW:0]   wp, rp;
  logic [AW-1:0] wa, ra;
  logic [W-1:0]  mem_data [DEPTH];
  logic [1:0]    mem_sel  [DEPTH];
  logic [TW-1:0] timer;
  logic [W-1:0]  a_in_q, rsp_cnt_q;
  logic [1:0]    sel_q;
  logic          rsp_err_q;
  logic          empty, full, push, pop, head_legal, timed_out, mismatch;
  assign wa         = wp[AW-1:0];
  assign ra         = rp[AW-1:0];
  assign empty      = wp == rp;
  assign full       = wp == {~rp[AW], rp[AW-1:0]};
  assign push       = bus.req_valid && !full;
  assign pop        = state == ISSUE || state == ILLEGAL;
  assign head_legal = mem_sel[ra] == 2'b10 || mem_sel[ra] == 2'b01;
  assign timed_out  = timer == TW'(TIMEOUT - 1);
`ifdef CNT_CHECK_EN
  logic [W-1:0] mem_ref [DEPTH];
  logic [W-1:0] ref_q;
  // X/Z bits match neither 1'b1 nor 1'b0 under ===, so they never count.
  function automatic logic [W-1:0] ref_cnt(input logic [W-1:0] d, input logic [1:0] s);
    ref_cnt = '0;
    for (int i = 0; i < W; i++)
      ref_cnt = ref_cnt + {{(W-1){1'b0}}, (s == 2'b10) ? (d[i] === 1'b1) : (d[i] === 1'b0)};
  endfunction
  always_ff @(posedge clk)
    if (push) mem_ref[wa] <= ref_cnt(bus.req_data, bus.req_sel);
  always_ff @(posedge clk or negedge rst)
    if (!rst) ref_q <= '0;
    else if (state == IDLE && !empty && head_legal) ref_q <= mem_ref[ra];
  assign mismatch = bus.cntout != ref_q;
`else
  assign mismatch = 1'b0;
`endif
  always_ff @(posedge clk)
    if (push) begin
      mem_data[wa] <= bus.req_data;
      mem_sel[wa]  <= bus.req_sel;
    end
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = empty ? IDLE : (head_legal ? ISSUE : ILLEGAL);
      ISSUE:   nxt = WAIT;
      WAIT:    nxt = (bus.done || timed_out) ? RESP : WAIT;
      ILLEGAL: nxt = RESP;
      RESP:    nxt = bus.rsp_ready ? IDLE : RESP;
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state     <= IDLE;
      wp        <= '0;
      rp        <= '0;
      timer     <= '0;
      a_in_q    <= '0;
      sel_q     <= '0;
      rsp_cnt_q <= '0;
      rsp_err_q <= 1'b0;
    end else begin
      state <= nxt;
      timer <= (state == WAIT) ? timer + TW'(1) : '0;
      if (push) wp <= wp + (AW+1)'(1);
      if (pop) rp <= rp + (AW+1)'(1);
      if (state == IDLE && !empty && head_legal) begin
        a_in_q <= mem_data[ra];
        sel_q  <= mem_sel[ra];
      end
      // done wins over a timeout expiring in the same cycle
      if (state == WAIT && bus.done) begin
        rsp_cnt_q <= bus.cntout;
        rsp_err_q <= mismatch;
      end else if ((state == WAIT && timed_out) || state == ILLEGAL) begin
        rsp_cnt_q <= '0;
        rsp_err_q <= 1'b1;
      end
    end
  assign bus.req_ready = !full;
  assign bus.start     = state == ISSUE;
  assign bus.a_in      = a_in_q;
  assign bus.sel       = sel_q;
  assign bus.rsp_valid = state == RESP;
  assign bus.rsp_cnt   = rsp_cnt_q;
  assign bus.rsp_err   = rsp_err_q;
endmodule

// File: tb/tb_count_issuer.sv
// tb_count_issuer: directed checks of count_issuer against a behavioural count-unit model.
module tb_count_issuer;
  logic clk, rst;
  int checks = 0, errors = 0;
  int cyc = 0, starts = 0, start_cyc = 0, push_cyc = 0, rsp_cyc = 0;
  int model_dly = 0, model_val = -1, wait_n = 0, pulse_req = 0, pulse_seen = 0;
  logic [7:0] cap_a;
  logic [1:0] cap_sel;
  count_issuer_if #(.W(8)) bus ();
  count_issuer #(.W(8), .DEPTH(4), .TIMEOUT(12)) dut (.clk(clk), .rst(rst), .bus(bus));
  initial clk = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic logic [7:0] pc(input logic [7:0] a, input logic [1:0] s);
    pc = 0;
    for (int i = 0; i < 8; i++) pc = pc + 8'(a[i] == (s == 2'b10));
  endfunction
  // count-unit model: done after model_dly cycles (0 = never), result model_val or true count
  initial begin
    bus.done = 0;
    bus.cntout = 0;
    forever begin
      @(negedge clk);
      bus.done = 0;
      if (!rst) wait_n = 0;
      if (pulse_seen != pulse_req) begin
        bus.done = 1;
        pulse_seen = pulse_req;
      end else if (bus.start) begin
        starts++;
        start_cyc = cyc;
        cap_a = bus.a_in;
        cap_sel = bus.sel;
        wait_n = model_dly;
      end else if (wait_n > 0) begin
        wait_n--;
        if (wait_n == 0) begin
          check("a_in_hold", bus.a_in, cap_a);
          check("sel_hold", bus.sel, cap_sel);
          bus.cntout = model_val >= 0 ? 8'(model_val) : pc(cap_a, cap_sel);
          bus.done = 1;
        end
      end
    end
  end
  task automatic push(input logic [7:0] d, input logic [1:0] s);
    int n = 0;
    @(negedge clk);
    bus.req_valid = 1;
    bus.req_data = d;
    bus.req_sel = s;
    while (!bus.req_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("push_ready", bus.req_ready, 1);
    push_cyc = cyc;
    @(posedge clk);
    #1 bus.req_valid = 0;
  endtask
  task automatic get_rsp(input string tag, input logic [7:0] ec, input logic ee, input int stall);
    int n = 0;
    @(negedge clk);
    while (!bus.rsp_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_valid"}, bus.rsp_valid, 1);
    rsp_cyc = cyc;
    check({tag, "_cnt"}, bus.rsp_cnt, ec);
    check({tag, "_err"}, bus.rsp_err, ee);
    repeat (stall) begin
      @(negedge clk);
      check({tag, "_stall_valid"}, bus.rsp_valid, 1);
      check({tag, "_stall_cnt"}, bus.rsp_cnt, ec);
      check({tag, "_stall_err"}, bus.rsp_err, ee);
    end
    bus.rsp_ready = 1;
    @(posedge clk);
    #1 bus.rsp_ready = 0;
  endtask
  initial begin
    int s0, n;
    logic exp_mis;
    bus.req_valid = 0;
    bus.req_data = 0;
    bus.req_sel = 0;
    bus.rsp_ready = 0;
    rst = 1;
    #1 rst = 0;
    repeat (3) @(negedge clk);
    check("rst_req_ready", bus.req_ready, 1);
    check("rst_start", bus.start, 0);
    check("rst_a_in", bus.a_in, 0);
    check("rst_sel", bus.sel, 0);
    check("rst_rsp_valid", bus.rsp_valid, 0);
    check("rst_rsp_cnt", bus.rsp_cnt, 0);
    check("rst_rsp_err", bus.rsp_err, 0);
    rst = 1;
    // count ones, done after 8 cycles
    model_dly = 8; model_val = 3; s0 = starts;
    push(8'b0000_1011, 2'b10);
    get_rsp("ones", 8'd3, 1'b0, 1);
    check("ones_starts", starts - s0, 1);
    check("ones_start_lat", start_cyc - push_cyc, 2);
    check("ones_rsp_lat", rsp_cyc - start_cyc, 9);
    check("ones_a_in", cap_a, 8'h0B);
    check("ones_sel", cap_sel, 2'b10);
    // count zeros; req_data changes after push
    model_dly = 3; model_val = 7; s0 = starts;
    push(8'b0000_0100, 2'b01);
    bus.req_data = 8'hFF;
    get_rsp("zeros", 8'd7, 1'b0, 0);
    check("zeros_starts", starts - s0, 1);
    check("zeros_a_in", cap_a, 8'h04);
    check("zeros_sel", cap_sel, 2'b01);
    // illegal select
    s0 = starts;
    push(8'h55, 2'b11);
    get_rsp("illegal", 8'd0, 1'b1, 0);
    check("illegal_starts", starts - s0, 0);
    check("illegal_lat", rsp_cyc - push_cyc, 3);
    // timeout, then a normal request
    model_dly = 0; model_val = -1;
    push(8'h0F, 2'b10);
    get_rsp("timeout", 8'd0, 1'b1, 0);
    check("timeout_lat", rsp_cyc - start_cyc, 13);
    model_dly = 2;
    push(8'h0F, 2'b10);
    get_rsp("after_to", 8'd4, 1'b0, 0);
    // backpressure: five pushes with responses stalled
    model_dly = 1;
    push(8'h01, 2'b10);
    push(8'h03, 2'b10);
    push(8'h07, 2'b10);
    push(8'h0F, 2'b10);
    push(8'h1F, 2'b01);
    @(negedge clk);
    check("bp_full", bus.req_ready, 0);
    repeat (3) @(negedge clk);
    check("bp_full_hold", bus.req_ready, 0);
    get_rsp("bp1", 8'd1, 1'b0, 2);
    get_rsp("bp2", 8'd2, 1'b0, 2);
    get_rsp("bp3", 8'd3, 1'b0, 1);
    get_rsp("bp4", 8'd4, 1'b0, 1);
    get_rsp("bp5", 8'd3, 1'b0, 1);
    @(negedge clk);
    check("bp_drained", bus.req_ready, 1);
    // asynchronous reset during WAIT, then a late done
    model_dly = 0; s0 = starts;
    push(8'h0F, 2'b10);
    n = 0;
    while (starts == s0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("mid_started", starts - s0, 1);
    repeat (3) @(negedge clk);
    #2 rst = 0;
    #1;
    check("arst_start", bus.start, 0);
    check("arst_a_in", bus.a_in, 0);
    check("arst_sel", bus.sel, 0);
    check("arst_rsp_valid", bus.rsp_valid, 0);
    check("arst_rsp_cnt", bus.rsp_cnt, 0);
    check("arst_rsp_err", bus.rsp_err, 0);
    check("arst_req_ready", bus.req_ready, 1);
    repeat (2) @(negedge clk);
    rst = 1;
    s0 = starts;
    pulse_req++;
    repeat (5) begin
      @(negedge clk);
      check("late_done_rsp", bus.rsp_valid, 0);
    end
    check("late_done_starts", starts - s0, 0);
    // wrong count from the unit
    model_dly = 2; model_val = 5;
`ifdef CNT_CHECK_EN
    exp_mis = 1'b1;
`else
    exp_mis = 1'b0;
`endif
    push(8'b0000_1011, 2'b10);
    get_rsp("mismatch", 8'd5, exp_mis, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
